// File: rtl/nd_bus_pkg.sv
// Shared types and constants for the ND-bus master sequencer.
package nd_bus_pkg;

  localparam int unsigned NdAddrW = 24;
  localparam int unsigned NdDataW = 16;
  localparam int unsigned CntW    = 8;

  localparam int unsigned DefAddrSetup  = 2;
  localparam int unsigned DefAprWidth   = 3;
  localparam int unsigned DefDataSetup  = 1;
  localparam int unsigned DefGntTimeout = 200;
  localparam int unsigned DefRdyTimeout = 250;

  typedef enum logic [3:0] {
    StIdle,
    StReq,
    StAddr,
    StApr,
    StData,
    StWaitRdy,
    StRelease,
    StDone,
    StErr
  } state_e;

  // Counter value on the final cycle of a state that lasts `cycles` cycles.
  function automatic logic [CntW-1:0] last_cnt(input int unsigned cycles);
    return (cycles == 0) ? '0 : CntW'(cycles - 1);
  endfunction

endpackage

// File: rtl/nd_bus_master_seq_if.sv
// CPU request port and ND-bus backplane signals of the bus master sequencer.
interface nd_bus_master_seq_if;
  import nd_bus_pkg::*;

  logic               cpu_req;
  logic               cpu_write;
  logic [NdAddrW-1:0] cpu_addr;
  logic [NdDataW-1:0] cpu_wdata;
  logic               cpu_ack;
  logic               cpu_err;
  logic [NdDataW-1:0] cpu_rdata;

  logic               BREQ_n;
  logic               BGNT_n;
  logic               BAPR_n;
  logic               BDAP_n;
  logic               BDRY_n;
  logic [NdAddrW-1:0] BA_OUT;
  logic               BA_OE;
  logic [NdDataW-1:0] BD_OUT;
  logic               BD_OE;
  logic [NdDataW-1:0] BD_IN;

  modport master (
    input  cpu_req, cpu_write, cpu_addr, cpu_wdata, BGNT_n, BDRY_n, BD_IN,
    output cpu_ack, cpu_err, cpu_rdata, BREQ_n, BAPR_n, BDAP_n, BA_OUT, BA_OE, BD_OUT, BD_OE
  );

  modport slave (
    output cpu_req, cpu_write, cpu_addr, cpu_wdata, BGNT_n, BDRY_n, BD_IN,
    input  cpu_ack, cpu_err, cpu_rdata, BREQ_n, BAPR_n, BDAP_n, BA_OUT, BA_OE, BD_OUT, BD_OE
  );

endinterface

// File: rtl/nd_bus_sync.sv
// Two-flop synchroniser for asynchronous backplane inputs.
module nd_bus_sync #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/nd_bus_master_seq.sv
// ND-bus initiator: runs one CPU read/write as a full arbitrated bus cycle.
module nd_bus_master_seq
  import nd_bus_pkg::*;
#(
  parameter int unsigned ADDR_SETUP  = DefAddrSetup,
  parameter int unsigned APR_WIDTH   = DefAprWidth,
  parameter int unsigned DATA_SETUP  = DefDataSetup,
  parameter int unsigned GNT_TIMEOUT = DefGntTimeout,
  parameter int unsigned RDY_TIMEOUT = DefRdyTimeout
) (
  input logic                 sysclk,
  input logic                 sys_rst,
  nd_bus_master_seq_if.master bus
);

  logic gnt_s, rdy_s;

  nd_bus_sync #(.ResetVal(1'b1)) u_sync_gnt (
    .clk_i (sysclk),
    .rst_i (sys_rst),
    .d_i   (bus.BGNT_n),
    .q_o   (gnt_s)
  );

  nd_bus_sync #(.ResetVal(1'b1)) u_sync_rdy (
    .clk_i (sysclk),
    .rst_i (sys_rst),
    .d_i   (bus.BDRY_n),
    .q_o   (rdy_s)
  );

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NdAddrW-1:0] addr_q, addr_d;
  logic [NdDataW-1:0] wdata_q, wdata_d;
  logic [NdDataW-1:0] rdata_q, rdata_d;
  logic               write_q, write_d;
  logic               breq_n_q, breq_n_d;
  logic               bapr_n_q, bapr_n_d;
  logic               bdap_n_q, bdap_n_d;
  logic               ba_oe_q, ba_oe_d;
  logic               bd_oe_q, bd_oe_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;

    case (state_q)
      StIdle: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          write_d = bus.cpu_write;
          state_d = StReq;
        end
      end
      StReq: begin
        if (!gnt_s) begin
          state_d = StAddr;
        end else if (GNT_TIMEOUT != 0 && cnt_q == last_cnt(GNT_TIMEOUT)) begin
          state_d = StErr;
        end
      end
      StAddr:  if (cnt_q == last_cnt(ADDR_SETUP)) state_d = StApr;
      StApr:   if (cnt_q == last_cnt(APR_WIDTH))  state_d = StData;
      StData:  if (cnt_q == last_cnt(DATA_SETUP)) state_d = StWaitRdy;
      StWaitRdy: begin
        if (!rdy_s) begin
          if (!write_q) rdata_d = bus.BD_IN;
          state_d = StRelease;
        end else if (RDY_TIMEOUT != 0 && cnt_q == last_cnt(RDY_TIMEOUT)) begin
          state_d = StErr;
        end
      end
      // Hold the bus until the responder has withdrawn BDRY.
      StRelease: if (rdy_s) state_d = StDone;
      StDone:    state_d = StIdle;
      StErr:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == {CntW{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Strobes are decoded from the next state so they leave the flops glitch-free.
    breq_n_d = !(state_d inside {StReq, StAddr, StApr, StData, StWaitRdy, StRelease});
    bapr_n_d = (state_d != StApr);
    bdap_n_d = (state_d != StWaitRdy);
    ba_oe_d  = state_d inside {StAddr, StApr, StData, StWaitRdy};
    bd_oe_d  = write_d && (state_d inside {StData, StWaitRdy});
    ack_d    = state_d inside {StDone, StErr};
    err_d    = (state_d == StErr);
  end

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      rdata_q  <= '0;
      breq_n_q <= 1'b1;
      bapr_n_q <= 1'b1;
      bdap_n_q <= 1'b1;
      ba_oe_q  <= 1'b0;
      bd_oe_q  <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      rdata_q  <= rdata_d;
      breq_n_q <= breq_n_d;
      bapr_n_q <= bapr_n_d;
      bdap_n_q <= bdap_n_d;
      ba_oe_q  <= ba_oe_d;
      bd_oe_q  <= bd_oe_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign bus.BREQ_n    = breq_n_q;
  assign bus.BAPR_n    = bapr_n_q;
  assign bus.BDAP_n    = bdap_n_q;
  assign bus.BA_OE     = ba_oe_q;
  assign bus.BD_OE     = bd_oe_q;
  assign bus.BA_OUT    = addr_q;
  assign bus.BD_OUT    = wdata_q;
  assign bus.cpu_ack   = ack_q;
  assign bus.cpu_err   = err_q;
  assign bus.cpu_rdata = rdata_q;

endmodule

// File: tb/tb_nd_bus_master_seq.sv
// Directed bench for nd_bus_master_seq with a hand-driven responder and a strobe monitor.
module tb_nd_bus_master_seq;

  localparam int SelDap = 0;
  localparam int SelApr = 1;
  localparam int SelAck = 2;
  localparam int SelReq = 3;

  logic sysclk;
  logic sys_rst;
  int   n_cmp = 0;
  int   n_err = 0;

  nd_bus_master_seq_if bus ();

  nd_bus_master_seq dut (
    .sysclk  (sysclk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor: running totals and values captured at strobe edges.
  int          tot_ack = 0, tot_err = 0, tot_apr_low = 0, tot_dap_low = 0;
  int          tot_breq_low = 0, tot_bdoe = 0, tot_both_low = 0;
  int          ba_pre = 0, pre_at_apr = 0, apr_run = 0, apr_len_last = 0;
  int          bd_pre = 0, bdpre_at_dap = 0;
  logic [23:0] addr_at_apr = '0;
  logic [15:0] bdout_at_dap = '0;
  logic        bdoe_at_dap = 1'b0;
  logic        prev_apr = 1'b1, prev_dap = 1'b1;

  always @(negedge sysclk) begin
    if (bus.cpu_ack) tot_ack <= tot_ack + 1;
    if (bus.cpu_err) tot_err <= tot_err + 1;
    if (!bus.BAPR_n) tot_apr_low <= tot_apr_low + 1;
    if (!bus.BDAP_n) tot_dap_low <= tot_dap_low + 1;
    if (!bus.BREQ_n) tot_breq_low <= tot_breq_low + 1;
    if (bus.BD_OE) tot_bdoe <= tot_bdoe + 1;
    if (!bus.BAPR_n && !bus.BDAP_n) tot_both_low <= tot_both_low + 1;
    if (!bus.BAPR_n && prev_apr) begin
      pre_at_apr  <= ba_pre;
      addr_at_apr <= bus.BA_OUT;
    end
    ba_pre <= !bus.BA_OE ? 0 : (bus.BAPR_n ? ba_pre + 1 : ba_pre);
    if (!bus.BAPR_n) begin
      apr_run <= apr_run + 1;
    end else begin
      if (!prev_apr) apr_len_last <= apr_run;
      apr_run <= 0;
    end
    if (!bus.BDAP_n && prev_dap) begin
      bdpre_at_dap <= bd_pre;
      bdoe_at_dap  <= bus.BD_OE;
      bdout_at_dap <= bus.BD_OUT;
    end
    bd_pre   <= !bus.BD_OE ? 0 : (bus.BDAP_n ? bd_pre + 1 : bd_pre);
    prev_apr <= bus.BAPR_n;
    prev_dap <= bus.BDAP_n;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      SelDap:  return bus.BDAP_n;
      SelApr:  return bus.BAPR_n;
      SelAck:  return bus.cpu_ack;
      default: return bus.BREQ_n;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic val, input int limit, input string tag,
                          output int cyc);
    cyc = 0;
    while (pick(sel) !== val && cyc < limit) begin
      tick(1);
      cyc++;
    end
    check(tag, 32'(pick(sel) === val), 32'd1);
  endtask

  // Responder: assert BDRY `delay` cycles after BDAP, release once BDAP is withdrawn.
  task automatic serve(input logic [15:0] data, input int delay, output int rel_cyc,
                       output int ack_cyc);
    int c;
    wait_for(SelDap, 1'b0, 60, "bdap_assert", c);
    tick(delay);
    bus.BD_IN  = data;
    bus.BDRY_n = 1'b0;
    wait_for(SelDap, 1'b1, 20, "bdap_release", rel_cyc);
    bus.BDRY_n = 1'b1;
    wait_for(SelAck, 1'b1, 20, "ack_arrive", ack_cyc);
  endtask

  initial begin
    int rel, ackc, c, s_ack, s_err, s_apr, s_dap, s_breq, s_bdoe, s_both;

    sys_rst       = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.BGNT_n    = 1'b0;
    bus.BDRY_n    = 1'b1;
    bus.BD_IN     = '0;

    // Reset state
    tick(2);
    check("rst_breq", 32'(bus.BREQ_n), 32'd1);
    check("rst_bapr", 32'(bus.BAPR_n), 32'd1);
    check("rst_bdap", 32'(bus.BDAP_n), 32'd1);
    check("rst_oe", 32'({bus.BA_OE, bus.BD_OE}), 32'd0);
    check("rst_ackerr", 32'({bus.cpu_ack, bus.cpu_err}), 32'd0);
    check("rst_rdata", 32'(bus.cpu_rdata), 32'd0);
    check("rst_ba_out", 32'(bus.BA_OUT), 32'd0);
    check("rst_bd_out", 32'(bus.BD_OUT), 32'd0);
    sys_rst = 1'b0;
    tick(3);

    // 1: read with grant tied low, BDRY 4 cycles after BDAP
    s_ack = tot_ack; s_bdoe = tot_bdoe; s_both = tot_both_low;
    bus.cpu_addr  = 24'h000100;
    bus.cpu_write = 1'b0;
    bus.cpu_req   = 1'b1;
    serve(16'hA5C3, 4, rel, ackc);
    bus.cpu_req = 1'b0;
    check("rd_rdata", 32'(bus.cpu_rdata), 32'hA5C3);
    check("rd_err", 32'(bus.cpu_err), 32'd0);
    check("rd_bdap_rel_lat", 32'(rel), 32'd3);
    check("rd_ack_lat", 32'(ackc), 32'd3);
    tick(1);
    check("rd_ack_pulse", 32'(bus.cpu_ack), 32'd0);
    check("rd_ack_count", 32'(tot_ack - s_ack), 32'd1);
    check("rd_no_bdoe", 32'(tot_bdoe - s_bdoe), 32'd0);
    check("rd_no_overlap", 32'(tot_both_low - s_both), 32'd0);
    tick(2);

    // 2: write timing
    s_ack = tot_ack; s_err = tot_err;
    bus.cpu_addr  = 24'h01F000;
    bus.cpu_wdata = 16'h1234;
    bus.cpu_write = 1'b1;
    bus.cpu_req   = 1'b1;
    serve(16'h0000, 1, rel, ackc);
    bus.cpu_req = 1'b0;
    tick(1);
    check("wr_addr_at_apr", 32'(addr_at_apr), 32'h01F000);
    check("wr_addr_setup", 32'(pre_at_apr), 32'd2);
    check("wr_apr_width", 32'(apr_len_last), 32'd3);
    check("wr_bdoe_at_dap", 32'(bdoe_at_dap), 32'd1);
    check("wr_bdout_at_dap", 32'(bdout_at_dap), 32'h1234);
    check("wr_data_setup", 32'(bdpre_at_dap), 32'd1);
    check("wr_ack_count", 32'(tot_ack - s_ack), 32'd1);
    check("wr_err_count", 32'(tot_err - s_err), 32'd0);
    check("wr_rdata_kept", 32'(bus.cpu_rdata), 32'hA5C3);
    tick(2);

    // 3: grant never arrives
    bus.BGNT_n = 1'b1;
    tick(3);
    s_ack = tot_ack; s_apr = tot_apr_low; s_breq = tot_breq_low;
    bus.cpu_write = 1'b0;
    bus.cpu_addr  = 24'h000200;
    bus.cpu_req   = 1'b1;
    wait_for(SelAck, 1'b1, 300, "gto_ack_arrive", c);
    bus.cpu_req = 1'b0;
    check("gto_err_with_ack", 32'(bus.cpu_err), 32'd1);
    check("gto_breq_released", 32'(bus.BREQ_n), 32'd1);
    tick(1);
    check("gto_breq_cycles", 32'(tot_breq_low - s_breq), 32'd200);
    check("gto_no_apr", 32'(tot_apr_low - s_apr), 32'd0);
    check("gto_ack_count", 32'(tot_ack - s_ack), 32'd1);
    check("gto_rdata_kept", 32'(bus.cpu_rdata), 32'hA5C3);
    bus.BGNT_n = 1'b0;
    tick(3);

    // 4: responder never answers
    s_dap = tot_dap_low;
    bus.BD_IN   = 16'hFFFF;
    bus.cpu_req = 1'b1;
    wait_for(SelDap, 1'b0, 60, "rto_bdap_assert", c);
    wait_for(SelDap, 1'b1, 300, "rto_bdap_release", c);
    check("rto_ack", 32'(bus.cpu_ack), 32'd1);
    check("rto_err", 32'(bus.cpu_err), 32'd1);
    bus.cpu_req = 1'b0;
    tick(1);
    check("rto_bdap_cycles", 32'(tot_dap_low - s_dap), 32'd250);
    check("rto_rdata_kept", 32'(bus.cpu_rdata), 32'hA5C3);
    tick(2);

    // 5: reset while waiting for BDRY
    s_ack = tot_ack;
    bus.cpu_req = 1'b1;
    wait_for(SelDap, 1'b0, 60, "mrst_bdap_assert", c);
    tick(2);
    sys_rst     = 1'b1;
    bus.cpu_req = 1'b0;
    #2;
    check("mrst_strobes", 32'({bus.BREQ_n, bus.BAPR_n, bus.BDAP_n}), 32'h7);
    check("mrst_oe", 32'({bus.BA_OE, bus.BD_OE}), 32'd0);
    tick(2);
    sys_rst = 1'b0;
    tick(3);
    check("mrst_no_ack", 32'(tot_ack - s_ack), 32'd0);
    bus.cpu_addr = 24'h000300;
    bus.cpu_req  = 1'b1;
    serve(16'h5A3C, 2, rel, ackc);
    bus.cpu_req = 1'b0;
    check("mrst_next_rdata", 32'(bus.cpu_rdata), 32'h5A3C);
    check("mrst_next_err", 32'(bus.cpu_err), 32'd0);
    tick(2);

    // 6: address changes mid-cycle and cpu_req is held across the ack
    s_ack = tot_ack;
    bus.cpu_addr = 24'hABCDEF;
    bus.cpu_req  = 1'b1;
    wait_for(SelApr, 1'b0, 30, "hold_apr1", c);
    check("hold_addr1", 32'(bus.BA_OUT), 32'hABCDEF);
    bus.cpu_addr = 24'h123456;
    tick(1);
    check("hold_addr1_stable", 32'(bus.BA_OUT), 32'hABCDEF);
    serve(16'h0F0F, 2, rel, ackc);
    check("hold_rdata1", 32'(bus.cpu_rdata), 32'h0F0F);
    wait_for(SelReq, 1'b0, 5, "hold_rereq", c);
    check("hold_rereq_lat", 32'(c), 32'd2);
    bus.cpu_req = 1'b0;
    wait_for(SelApr, 1'b0, 30, "hold_apr2", c);
    check("hold_addr2", 32'(bus.BA_OUT), 32'h123456);
    serve(16'hF0F0, 1, rel, ackc);
    check("hold_rdata2", 32'(bus.cpu_rdata), 32'hF0F0);
    tick(1);
    check("hold_ack_count", 32'(tot_ack - s_ack), 32'd2);
    check("all_no_overlap", 32'(tot_both_low), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nd_bus_master_seq.md
Name: nd_bus_master_seq

Overview:
- CPU-side initiator for ND-bus cycles. It is the opposite end of the local data bus control, which responds when an external master accesses local memory.
- Takes one CPU request at a time and runs the full bus cycle: arbitrate with BREQ/BGNT, drive the address and strobe BAPR, drive or receive data and strobe BDAP, wait for the responder's BDRY, then release the bus.
- Sits between the CPU memory interface and the backplane transceivers.

Parameters:
ADDR_SETUP, 2, cycles address is driven before BAPR asserts
APR_WIDTH, 3, cycles BAPR_n held low
DATA_SETUP, 1, cycles data (write) or bus turnaround (read) before BDAP asserts
GNT_TIMEOUT, 200, cycles to wait for synced grant; 0 disables the timeout
RDY_TIMEOUT, 250, cycles to wait for synced BDRY; 0 disables the timeout

Ports:
sysclk  in  1  system clock
sys_rst  in  1  reset, asynchronous, active-high
cpu_req  in  1  request; held high until cpu_ack
cpu_write  in  1  1 = write, 0 = read; sampled with cpu_req
cpu_addr  in  24  bus address
cpu_wdata  in  16  write data
cpu_ack  out  1  one-cycle completion pulse
cpu_err  out  1  one-cycle pulse, coincident with cpu_ack on timeout
cpu_rdata  out  16  read data; valid from cpu_ack until the next read completes
BREQ_n  out  1  bus request
BGNT_n  in  1  bus grant, asynchronous
BAPR_n  out  1  address present
BDAP_n  out  1  data present
BDRY_n  in  1  data ready from responder, asynchronous
BA_OUT  out  24  address to the bus transceivers
BA_OE  out  1  address drive enable
BD_OUT  out  16  data to the bus transceivers
BD_OE  out  1  data drive enable (writes only)
BD_IN  in  16  data from the bus

Behaviour:
- Reset (async, while sys_rst high): state IDLE. All *_n outputs 1, BA_OE=BD_OE=0, cpu_ack=cpu_err=0, cpu_rdata=0, BA_OUT=BD_OUT=0, counters cleared. Reset mid-cycle drops all bus drive immediately, with no completion pulse.
- Synchronisers: BGNT_n and BDRY_n each pass through 2 flops, each flop resetting to 1. All decisions use the synced versions (gnt_s, rdy_s).
- One shared 8-bit cycle counter cnt: reloaded on every state entry; saturates at 255 in wait states.
- IDLE: cpu_req=1 latches cpu_addr, cpu_wdata and cpu_write into internal registers. Next state REQ, with BREQ_n=0 in the next cycle.
- REQ: wait for gnt_s=0 → ADDR. If GNT_TIMEOUT≠0 and cnt reaches GNT_TIMEOUT first → ERR.
- ADDR: BA_OE=1, BA_OUT=latched address. After ADDR_SETUP cycles → APR.
- APR: BAPR_n=0 for exactly APR_WIDTH cycles → DATA. BA_OE stays 1 through DATA.
- DATA:
  - BAPR_n=1.
  - Write: BD_OE=1, BD_OUT=latched data.
  - After DATA_SETUP cycles, BDAP_n=0 → WAIT_RDY.
- WAIT_RDY:
  - BDAP_n stays 0 until rdy_s=0.
  - In the cycle rdy_s is first seen low, a read registers BD_IN into cpu_rdata → RELEASE.
  - If RDY_TIMEOUT≠0 and cnt reaches RDY_TIMEOUT first → ERR.
- RELEASE: BDAP_n=1, BA_OE=0, BD_OE=0, BREQ_n stays 0. When rdy_s=1 → DONE.
- DONE: BREQ_n=1, cpu_ack=1 for one cycle → IDLE.
- ERR: BREQ_n, BAPR_n and BDAP_n all 1, both OEs 0, cpu_ack=cpu_err=1 for one cycle → IDLE. cpu_rdata is unchanged.
- Minimum latency, read, grant already present:
  - BREQ low at cycle 1, gnt_s seen at cycle 3.
  - BAPR cycles 3+ADDR_SETUP .. +APR_WIDTH−1.
  - BDAP follows after DATA_SETUP.
  - cpu_ack comes ≥2 cycles after BDRY returns high.
- cpu_req changes while busy: ignored; the latched request is used.
- cpu_req still high in the cycle after DONE: this is a new request, because the CPU must drop cpu_req on seeing cpu_ack.
- BGNT lost mid-cycle: ignored (the bus owner finishes its cycle).
- BDRY glitch shorter than 2 cycles: may be missed by the synchroniser. This is acceptable; the timeout covers it.
- BAPR_n and BDAP_n are never low in the same cycle. BD_OE is never 1 during a read.

Decomposition:
- Package nd_bus_pkg:
  - state enum: IDLE, REQ, ADDR, APR, DATA, WAIT_RDY, RELEASE, DONE, ERR
  - default timing constants
  - ND-bus address and data width constants: 24, 16
- Sub-module nd_bus_sync: 2-flop synchroniser, async reset value parameterised to 1. Instantiated for BGNT_n and BDRY_n.

Test Plan:
- Read, BGNT_n tied low, responder asserts BDRY_n 4 cycles after BDAP with BD_IN=16'hA5C3 → cpu_rdata=16'hA5C3, single cpu_ack, cpu_err=0, BD_OE never 1.
- Write, cpu_addr=24'h01F000, cpu_wdata=16'h1234 → BA_OUT=24'h01F000 with BA_OE=1 for ≥ADDR_SETUP cycles before BAPR_n=0. BAPR_n low exactly 3 cycles. BD_OUT=16'h1234 with BD_OE=1 before BDAP_n=0.
- BGNT_n held high → BREQ_n low for ~200 cycles, then cpu_ack=cpu_err=1 in the same cycle, BREQ_n returns to 1, no BAPR.
- BDRY_n never asserted → BDAP_n released after the 250-cycle timeout; cpu_err pulse; cpu_rdata keeps its previous value.
- sys_rst pulsed during WAIT_RDY → all strobes high and OEs 0 asynchronously; no cpu_ack; the next request completes normally.
- cpu_addr changed mid-cycle and cpu_req held across cpu_ack → first cycle uses the original address; a second full bus cycle follows.
